// File: rtl/fcw_sweep.sv
// fcw_sweep: frequency-control-word sweep generator feeding the nco fcw input.
// Steps fcw linearly from start_fcw to stop_fcw. Each word is held for dwell+1
// cycles. The sweep runs once or loops continuously.
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous active-low reset
//   start      sweep request, accepted only in IDLE (abort has priority)
//   abort      terminate sweep, return to IDLE, fcw holds
//   loop_en    1 = reload start_fcw after stop_fcw, sampled continuously
//   start_fcw  first word, latched on accepted start
//   stop_fcw   last word, latched on accepted start
//   step       increment, latched on accepted start
//   dwell      hold count, latched on accepted start
//   fcw        frequency control word to nco
//   busy       high in DWELL or STEP
//   done       one-cycle pulse when a one-shot sweep completes
//   wrap       one-cycle pulse in the cycle a looping sweep reloads start_fcw
//
// state | meaning
// IDLE  | no sweep, fcw holds its last value
// DWELL | holding the current word, counter running toward latched dwell
// STEP  | first cycle of a freshly stepped or reloaded word (counter = 0)
//
// The next word is computed in the last dwell cycle, so it is already on fcw
// during STEP. STEP therefore counts as the first hold cycle of the new word,
// and each word occupies exactly dwell+1 cycles.
module fcw_sweep #(
  parameter int W  = 16,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic          loop_en,
  input  logic [W-1:0]  start_fcw,
  input  logic [W-1:0]  stop_fcw,
  input  logic [W-1:0]  step,
  input  logic [DW-1:0] dwell,
  output logic [W-1:0]  fcw,
  output logic          busy,
  output logic          done,
  output logic          wrap
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DWELL = 2'd1;
  localparam logic [1:0] STEP  = 2'd2;

  logic [1:0]    state;
  logic [DW-1:0] cnt;
  logic [W-1:0]  start_q;
  logic [W-1:0]  stop_q;
  logic [W-1:0]  step_q;
  logic [DW-1:0] dwell_q;

  logic [W-1:0]  step_eff;
  logic          up;
  logic [W:0]    sum;
  logic [W:0]    diff;
  logic [W-1:0]  next_fcw;
  logic          at_stop;
  logic          terminal;

  // A zero step would stall the sweep forever; treat it as 1.
  assign step_eff = (step_q == '0) ? {{(W-1){1'b0}}, 1'b1} : step_q;
  assign up       = (stop_q >= start_q);
  assign sum      = {1'b0, fcw} + {1'b0, step_eff};
  assign diff     = {1'b0, fcw} - {1'b0, step_eff};
  assign at_stop  = (fcw == stop_q);
  assign terminal = (cnt == dwell_q);

  // Clamp to stop when the next word would overshoot it or leave W bits;
  // the extra MSB of sum/diff flags overflow/underflow.
  always_comb begin
    next_fcw = stop_q;
    if (up) begin
      if (!sum[W] && (sum[W-1:0] <= stop_q))
        next_fcw = sum[W-1:0];
    end else begin
      if (!diff[W] && (diff[W-1:0] >= stop_q))
        next_fcw = diff[W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      start_q <= '0;
      stop_q  <= '0;
      step_q  <= '0;
      dwell_q <= '0;
      fcw     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      wrap    <= 1'b0;
    end else begin
      done <= 1'b0;
      wrap <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !abort) begin
            start_q <= start_fcw;
            stop_q  <= stop_fcw;
            step_q  <= step;
            dwell_q <= dwell;
            fcw     <= start_fcw;
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= DWELL;
          end
        end
        DWELL, STEP: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (terminal) begin
            if (at_stop) begin
              if (loop_en) begin
                fcw   <= start_q;
                wrap  <= 1'b1;
                cnt   <= '0;
                state <= STEP;
              end else begin
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= IDLE;
              end
            end else begin
              fcw   <= next_fcw;
              cnt   <= '0;
              state <= STEP;
            end
          end else begin
            cnt   <= cnt + {{(DW-1){1'b0}}, 1'b1};
            state <= DWELL;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fcw_sweep.sv
// Directed bench for fcw_sweep: table of one-shot sweeps plus hand-written
// sequences for looping, abort, start rules and reset.
module tb_fcw_sweep;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic        loop_en;
  logic [15:0] start_fcw;
  logic [15:0] stop_fcw;
  logic [15:0] step;
  logic [15:0] dwell;
  logic [15:0] fcw;
  logic        busy;
  logic        done;
  logic        wrap;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fcw_sweep dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .loop_en   (loop_en),
    .start_fcw (start_fcw),
    .stop_fcw  (stop_fcw),
    .step      (step),
    .dwell     (dwell),
    .fcw       (fcw),
    .busy      (busy),
    .done      (done),
    .wrap      (wrap)
  );

  typedef struct {
    logic [15:0]       s;
    logic [15:0]       p;
    logic [15:0]       st;
    logic [15:0]       dw;
    int                n;
    logic [3:0][15:0]  v;
    int                nbusy;
  } vec_t;

  vec_t vecs [4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic launch(input logic [15:0] s, input logic [15:0] p,
                        input logic [15:0] st, input logic [15:0] dw);
    start_fcw = s;
    stop_fcw  = p;
    step      = st;
    dwell     = dw;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  logic [15:0] lexp [8];
  logic        wexp [8];

  initial begin
    reset = 1'b0; start = 1'b1; abort = 1'b0; loop_en = 1'b0;
    start_fcw = 16'd77; stop_fcw = 16'd99; step = 16'd1; dwell = 16'd0;

    vecs[0] = '{s:16'd100,  p:16'd130,  st:16'd10, dw:16'd2, n:4,
                v:{16'd130, 16'd120, 16'd110, 16'd100}, nbusy:12};
    vecs[1] = '{s:16'd4692, p:16'd4670, st:16'd10, dw:16'd0, n:4,
                v:{16'd4670, 16'd4672, 16'd4682, 16'd4692}, nbusy:4};
    vecs[2] = '{s:16'd5,    p:16'd7,    st:16'd0,  dw:16'd0, n:3,
                v:{16'd0, 16'd7, 16'd6, 16'd5}, nbusy:3};
    vecs[3] = '{s:16'd50,   p:16'd50,   st:16'd7,  dw:16'd3, n:1,
                v:{16'd0, 16'd0, 16'd0, 16'd50}, nbusy:4};

    // reset held with start high
    tick(); tick();
    chk("rst_fcw", 32'(fcw), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_wrap", 32'(wrap), 32'd0);
    start = 1'b0; reset = 1'b1;
    tick();
    chk("post_rst_idle", 32'(busy), 32'd0);
    chk("post_rst_fcw", 32'(fcw), 32'd0);

    // table of one-shot sweeps
    for (int i = 0; i < 4; i++) begin
      launch(vecs[i].s, vecs[i].p, vecs[i].st, vecs[i].dw);
      for (int k = 0; k < vecs[i].nbusy; k++) begin
        chk($sformatf("v%0d_fcw_c%0d", i, k), 32'(fcw),
            32'(vecs[i].v[k / (int'(vecs[i].dw) + 1)]));
        chk($sformatf("v%0d_busy_c%0d", i, k), 32'(busy), 32'd1);
        chk($sformatf("v%0d_dw_c%0d", i, k), 32'({done, wrap}), 32'd0);
        tick();
      end
      chk($sformatf("v%0d_done", i), 32'(done), 32'd1);
      chk($sformatf("v%0d_idle", i), 32'(busy), 32'd0);
      chk($sformatf("v%0d_hold", i), 32'(fcw), 32'(vecs[i].v[vecs[i].n - 1]));
      tick();
      chk($sformatf("v%0d_done_clr", i), 32'(done), 32'd0);
      chk($sformatf("v%0d_hold2", i), 32'(fcw), 32'(vecs[i].v[vecs[i].n - 1]));
    end

    // looping sweep with overflow clamp, then one-shot finish
    lexp = '{16'hFFF0, 16'hFFF0, 16'hFFFF, 16'hFFFF,
             16'hFFF0, 16'hFFF0, 16'hFFFF, 16'hFFFF};
    wexp = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    loop_en = 1'b1;
    launch(16'hFFF0, 16'hFFFF, 16'h0020, 16'd1);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("loop_fcw_c%0d", k), 32'(fcw), 32'(lexp[k]));
      chk($sformatf("loop_wrap_c%0d", k), 32'(wrap), 32'(wexp[k]));
      chk($sformatf("loop_done_c%0d", k), 32'(done), 32'd0);
      if (k == 7) loop_en = 1'b0;
      tick();
    end
    chk("loop_end_done", 32'(done), 32'd1);
    chk("loop_end_wrap", 32'(wrap), 32'd0);
    chk("loop_end_busy", 32'(busy), 32'd0);
    chk("loop_end_fcw", 32'(fcw), 32'hFFFF);
    tick();

    // start ignored while busy, config changes ignored, abort on 3rd cycle of 110
    launch(16'd100, 16'd130, 16'd10, 16'd2);
    tick();
    start = 1'b1; start_fcw = 16'd999; stop_fcw = 16'd1; step = 16'd500; dwell = 16'd9;
    tick();
    start = 1'b0;
    chk("busy_start_ign", 32'(fcw), 32'd100);
    tick();
    chk("abort_pre_110a", 32'(fcw), 32'd110);
    tick();
    chk("abort_pre_110b", 32'(fcw), 32'd110);
    tick();
    chk("abort_pre_110c", 32'(fcw), 32'd110);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_fcw", 32'(fcw), 32'd110);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_wrap", 32'(wrap), 32'd0);
    tick();
    chk("abort_stays_idle", 32'(busy), 32'd0);
    chk("abort_done_late", 32'(done), 32'd0);

    // start and abort together in IDLE
    start = 1'b1; abort = 1'b1; start_fcw = 16'd321;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("sa_busy", 32'(busy), 32'd0);
    chk("sa_fcw", 32'(fcw), 32'd110);

    // reset mid-sweep
    launch(16'd200, 16'd300, 16'd1, 16'd3);
    tick();
    chk("mid_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    tick();
    chk("midrst_fcw", 32'(fcw), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    reset = 1'b1;
    tick();
    chk("midrst_idle", 32'(busy), 32'd0);
    chk("midrst_fcw2", 32'(fcw), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
